// File: rtl/zigbee_test_pkg.sv
// Shared definitions for the zigbee test-probe serializer: probe mode encodings,
// serializer FSM states and a small sizing helper.
package zigbee_test_pkg;

    localparam int MODE_TXRX             = 0;
    localparam int MODE_FIFO_CDR         = 1;
    localparam int MODE_CORDIC_CDR_MODIQ = 2;
    localparam int MODE_CORDIC_DEMOD     = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DRAIN
    } ser_state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/zigbee_probe_fifo.sv
// Synchronous FIFO holding captured probe words. The pointers carry one extra wrap bit
// so that full and empty can be told apart without a separate occupancy counter.
module zigbee_probe_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; the pointers alone decide what is valid.
    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/zigbee_probe_serializer.sv
// Test-pad probe mux: captures the selected probe lane into a FIFO and streams each word
// LSB-beat-first over a narrow valid/ready pad bus, switching modes only once drained.
module zigbee_probe_serializer
    import zigbee_test_pkg::*;
#(
    parameter int NB_MODES = 4,
    parameter int PROBE_W  = 32,
    parameter int OUT_W    = 8,
    parameter int DEPTH    = 16,
    parameter int DROP_W   = 8,
    localparam int SEL_W   = $clog2(NB_MODES)
) (
    input  logic                         clk_i,
    input  logic                         resetn_i,
    input  logic [SEL_W-1:0]             sel_i,
    input  logic [NB_MODES*PROBE_W-1:0]  probe_i,
    input  logic [NB_MODES-1:0]          probe_valid_i,
    input  logic                         clear_i,
    output logic [OUT_W-1:0]             mux_o,
    output logic                         mux_valid_o,
    output logic                         mux_last_o,
    input  logic                         mux_ready_i,
    output logic [SEL_W-1:0]             mode_o,
    output logic                         mode_busy_o,
    output logic                         overflow_o,
    output logic [DROP_W-1:0]            drop_cnt_o
);

    localparam int BEATS   = ceil_div(PROBE_W, OUT_W);
    localparam int SHIFT_W = BEATS * OUT_W;
    localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    ser_state_t        state_q, state_d;
    logic [SEL_W-1:0]  mode_q, mode_d;
    logic              valid_q, valid_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [PROBE_W-1:0] fifo_rdata, lane_word;
    logic               lane_valid, push_req, drain_req;
    logic               handshake, beat_last, load;

    assign lane_word  = probe_i[mode_q*PROBE_W +: PROBE_W];
    assign lane_valid = probe_valid_i[mode_q];
    assign push_req   = lane_valid && (state_q != S_DRAIN);
    assign drain_req  = (sel_i != mode_q);

    assign beat_last  = (beat_q == BEAT_W'(BEATS - 1));
    assign handshake  = valid_q && mux_ready_i;
    // The shift register is free when idle or when its final beat leaves this edge.
    assign load       = (!valid_q || (handshake && beat_last)) && !fifo_empty;

    zigbee_probe_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PROBE_W)
    ) u_fifo (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .clear_i  (clear_i),
        .push_i   (fifo_push),
        .wdata_i  (lane_word),
        .pop_i    (fifo_pop),
        .rdata_o  (fifo_rdata),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        valid_d    = valid_q;
        beat_d     = beat_q;
        shift_d    = shift_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;

        if (clear_i) begin
            state_d    = S_IDLE;
            mode_d     = sel_i;
            valid_d    = 1'b0;
            beat_d     = '0;
            shift_d    = '0;
            overflow_d = 1'b0;
            drop_d     = '0;
        end else begin
            if (load) begin
                fifo_pop              = 1'b1;
                shift_d               = '0;
                shift_d[PROBE_W-1:0]  = fifo_rdata;
                beat_d                = '0;
                valid_d               = 1'b1;
            end else if (handshake) begin
                shift_d = shift_q >> OUT_W;
                if (beat_last) begin
                    valid_d = 1'b0;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end

            if (push_req) begin
                if (!fifo_full || fifo_pop) begin
                    fifo_push = 1'b1;
                end else begin
                    overflow_d = 1'b1;
                    if (drop_q != '1) drop_d = drop_q + 1'b1;
                end
            end

            // Draining keeps serializing; the new mode lands once nothing is left in flight.
            if (drain_req) begin
                if (state_q == S_DRAIN && fifo_empty && !valid_q) begin
                    state_d = S_IDLE;
                    mode_d  = sel_i;
                end else begin
                    state_d = S_DRAIN;
                end
            end else begin
                state_d = valid_d ? S_SEND : S_IDLE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q    <= S_IDLE;
            mode_q     <= SEL_W'(MODE_TXRX);
            valid_q    <= 1'b0;
            beat_q     <= '0;
            shift_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            valid_q    <= valid_d;
            beat_q     <= beat_d;
            shift_q    <= shift_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    assign mux_o       = shift_q[OUT_W-1:0];
    assign mux_valid_o = valid_q;
    assign mux_last_o  = valid_q && beat_last;
    assign mode_o      = mode_q;
    assign mode_busy_o = (state_q == S_DRAIN);
    assign overflow_o  = overflow_q;
    assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_zigbee_probe_serializer.sv
// Scoreboard bench for the probe serializer: a word-level capacity model predicts
// accepted words, drops and mode changes, and a monitor checks every beat on the pad bus.
module tb_zigbee_probe_serializer;
    import zigbee_test_pkg::*;

    localparam int NB_MODES = 4;
    localparam int PROBE_W  = 32;
    localparam int OUT_W    = 8;
    localparam int DEPTH    = 16;
    localparam int DROP_W   = 8;
    localparam int SEL_W    = 2;
    localparam int BEATS    = 4;
    localparam int DROP_MAX = 255;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic             last;
    } beat_t;

    logic                        clk_i = 1'b0;
    logic                        resetn_i = 1'b0;
    logic [SEL_W-1:0]            sel_i = '0;
    logic [NB_MODES*PROBE_W-1:0] probe_i;
    logic [NB_MODES-1:0]         probe_valid_i = '0;
    logic                        clear_i = 1'b0;
    logic [OUT_W-1:0]            mux_o;
    logic                        mux_valid_o;
    logic                        mux_last_o;
    logic                        mux_ready_i = 1'b0;
    logic [SEL_W-1:0]            mode_o;
    logic                        mode_busy_o;
    logic                        overflow_o;
    logic [DROP_W-1:0]           drop_cnt_o;

    logic [PROBE_W-1:0] lane_data [NB_MODES];

    int n_checks = 0;
    int n_fail   = 0;
    int beats_seen = 0;

    beat_t exp_q[$];
    int    m_mode, m_ins, m_drops;
    bit    m_busy, m_ovf;
    bit    done, prev_busy;
    int    prev_ins;
    beat_t nb;

    zigbee_probe_serializer #(
        .NB_MODES (NB_MODES),
        .PROBE_W  (PROBE_W),
        .OUT_W    (OUT_W),
        .DEPTH    (DEPTH),
        .DROP_W   (DROP_W)
    ) dut (
        .clk_i         (clk_i),
        .resetn_i      (resetn_i),
        .sel_i         (sel_i),
        .probe_i       (probe_i),
        .probe_valid_i (probe_valid_i),
        .clear_i       (clear_i),
        .mux_o         (mux_o),
        .mux_valid_o   (mux_valid_o),
        .mux_last_o    (mux_last_o),
        .mux_ready_i   (mux_ready_i),
        .mode_o        (mode_o),
        .mode_busy_o   (mode_busy_o),
        .overflow_o    (overflow_o),
        .drop_cnt_o    (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    always_comb begin
        probe_i = '0;
        for (int m = 0; m < NB_MODES; m++) probe_i[m*PROBE_W +: PROBE_W] = lane_data[m];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One-cycle strobe of a word on a lane; consumed by the next rising edge.
    task automatic applyStimulus(input int lane, input logic [PROBE_W-1:0] word);
        lane_data[lane]     = word;
        probe_valid_i[lane] = 1'b1;
        tick();
        probe_valid_i = '0;
    endtask

    // Monitor and reference model, evaluated mid-cycle while all signals are stable.
    // The model counts whole words held by the DUT: up to DEPTH in the FIFO plus one
    // being serialized; a word leaving on its last-beat handshake frees a slot that edge.
    always @(negedge clk_i) begin
        if (!resetn_i) begin
            exp_q.delete();
            m_mode = MODE_TXRX; m_ins = 0; m_drops = 0; m_busy = 0; m_ovf = 0;
        end else begin
            checkOutput("mode_o", 32'(mode_o), 32'(m_mode));
            checkOutput("mode_busy_o", 32'(mode_busy_o), 32'(m_busy));
            checkOutput("drop_cnt_o", 32'(drop_cnt_o), 32'(m_drops));
            checkOutput("overflow_o", 32'(overflow_o), 32'(m_ovf));
            done = 0;
            if (mux_valid_o) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_beat: got data 0x%0h with valid, expected no beat at %0t", mux_o, $time);
                end else begin
                    checkOutput("beat_data", 32'(mux_o), 32'(exp_q[0].data));
                    checkOutput("beat_last", 32'(mux_last_o), 32'(exp_q[0].last));
                    if (mux_ready_i) begin
                        done = exp_q[0].last;
                        beats_seen++;
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (clear_i) begin
                exp_q.delete();
                m_ins = 0; m_drops = 0; m_ovf = 0; m_busy = 0;
                m_mode = int'(sel_i);
            end else begin
                prev_busy = m_busy;
                prev_ins  = m_ins;
                if (probe_valid_i[m_mode] && !m_busy) begin
                    if (m_ins < DEPTH + 1 || done) begin
                        for (int k = 0; k < BEATS; k++) begin
                            nb.data = lane_data[m_mode][k*OUT_W +: OUT_W];
                            nb.last = (k == BEATS - 1);
                            exp_q.push_back(nb);
                        end
                        m_ins++;
                    end else begin
                        m_ovf = 1;
                        if (m_drops < DROP_MAX) m_drops++;
                    end
                end
                if (done) m_ins--;
                if (int'(sel_i) != m_mode) begin
                    if (prev_busy && prev_ins == 0) begin
                        m_mode = int'(sel_i);
                        m_busy = 0;
                    end else begin
                        m_busy = 1;
                    end
                end else begin
                    m_busy = 0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] word;
        logic [7:0]  dead_bytes [4];
        int          start_beats;
        int          guard;

        dead_bytes[0] = 8'hEF; dead_bytes[1] = 8'hBE; dead_bytes[2] = 8'hAD; dead_bytes[3] = 8'hDE;
        for (int m = 0; m < NB_MODES; m++) lane_data[m] = '0;

        // Reset held five cycles.
        repeat (5) tick();
        resetn_i = 1'b1;
        tick();
        checkOutput("rst_valid", 32'(mux_valid_o), 0);
        checkOutput("rst_mode", 32'(mode_o), 0);
        checkOutput("rst_drop", 32'(drop_cnt_o), 0);
        checkOutput("rst_ovf", 32'(overflow_o), 0);

        // Switch to lane 2 and stream one word.
        sel_i = SEL_W'(MODE_CORDIC_CDR_MODIQ);
        guard = 0;
        while (mode_o != 2 && guard < 50) begin tick(); guard++; end
        checkOutput("t2_mode", 32'(mode_o), 2);
        mux_ready_i = 1'b1;
        applyStimulus(2, 32'hDEADBEEF);
        checkOutput("t2_lat_edge_n", 32'(mux_valid_o), 0);
        tick();
        checkOutput("t2_lat_edge_n1", 32'(mux_valid_o), 1);
        for (int k = 0; k < BEATS; k++) begin
            checkOutput("t2_beat", 32'(mux_o), 32'(dead_bytes[k]));
            checkOutput("t2_last", 32'(mux_last_o), (k == BEATS - 1) ? 1 : 0);
            tick();
        end
        checkOutput("t2_idle", 32'(mux_valid_o), 0);

        // Backpressure on beat 1.
        mux_ready_i = 1'b0;
        applyStimulus(2, 32'hDEADBEEF);
        tick();
        mux_ready_i = 1'b1;
        tick();
        mux_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("t3_hold_data", 32'(mux_o), 32'hBE);
            checkOutput("t3_hold_valid", 32'(mux_valid_o), 1);
            tick();
        end
        mux_ready_i = 1'b1;
        tick();
        checkOutput("t3_resume_ad", 32'(mux_o), 32'hAD);
        tick();
        checkOutput("t3_resume_de", 32'(mux_o), 32'hDE);
        checkOutput("t3_resume_last", 32'(mux_last_o), 1);
        tick();

        // Overflow: 20 back-to-back strobes with the pad stalled.
        mux_ready_i = 1'b0;
        for (int i = 0; i < 20; i++) applyStimulus(2, $urandom);
        tick();
        checkOutput("t4_drops", 32'(drop_cnt_o), 3);
        checkOutput("t4_ovf", 32'(overflow_o), 1);
        start_beats = beats_seen;
        mux_ready_i = 1'b1;
        guard = 0;
        while (mux_valid_o && guard < 200) begin tick(); guard++; end
        checkOutput("t4_beats_out", 32'(beats_seen - start_beats), 17 * BEATS);

        // Mode switch with three words queued.
        mux_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(2, $urandom);
        start_beats = beats_seen;
        sel_i = SEL_W'(MODE_CORDIC_DEMOD);
        tick();
        for (int i = 0; i < 4; i++) applyStimulus(2, $urandom);
        checkOutput("t5_busy", 32'(mode_busy_o), 1);
        checkOutput("t5_mode_held", 32'(mode_o), 2);
        checkOutput("t5_drops_kept", 32'(drop_cnt_o), 3);
        mux_ready_i = 1'b1;
        guard = 0;
        while (mode_o != 3 && guard < 100) begin tick(); guard++; end
        checkOutput("t5_mode_new", 32'(mode_o), 3);
        checkOutput("t5_beats_out", 32'(beats_seen - start_beats), 3 * BEATS);
        tick();
        checkOutput("t5_busy_off", 32'(mode_busy_o), 0);

        // clear_i at beat 2.
        word = $urandom;
        applyStimulus(3, word);
        tick();
        tick();
        tick();
        checkOutput("t6_beat2", 32'(mux_o), 32'(word[23:16]));
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        checkOutput("t6_clr_valid", 32'(mux_valid_o), 0);
        checkOutput("t6_clr_drop", 32'(drop_cnt_o), 0);
        checkOutput("t6_clr_ovf", 32'(overflow_o), 0);
        checkOutput("t6_clr_mode", 32'(mode_o), 3);
        word = $urandom;
        applyStimulus(3, word);
        tick();
        checkOutput("t6_new_beat0", 32'(mux_o), 32'(word[7:0]));
        repeat (6) tick();

        // Same again with a reset pulse instead of clear_i.
        word = $urandom;
        applyStimulus(3, word);
        repeat (3) tick();
        sel_i    = '0;
        resetn_i = 1'b0;
        tick();
        resetn_i = 1'b1;
        tick();
        checkOutput("t6r_valid", 32'(mux_valid_o), 0);
        checkOutput("t6r_mode", 32'(mode_o), 0);
        word = $urandom;
        applyStimulus(0, word);
        tick();
        checkOutput("t6r_new_beat0", 32'(mux_o), 32'(word[7:0]));
        repeat (6) tick();

        // Randomized traffic on all lanes with stalls, mode changes and clears.
        for (int c = 0; c < 3000; c++) begin
            for (int m = 0; m < NB_MODES; m++) begin
                lane_data[m]     = $urandom;
                probe_valid_i[m] = ($urandom_range(0, 3) == 0);
            end
            mux_ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) sel_i = SEL_W'($urandom_range(0, NB_MODES - 1));
            clear_i = ($urandom_range(0, 199) == 0);
            tick();
        end
        probe_valid_i = '0;
        clear_i       = 1'b0;
        mux_ready_i   = 1'b1;
        guard = 0;
        while ((mux_valid_o || mode_busy_o || mode_o != sel_i) && guard < 500) begin tick(); guard++; end
        tick();
        checkOutput("end_idle", 32'(mux_valid_o), 0);
        checkOutput("end_pending_beats", 32'(exp_q.size()), 0);
        checkOutput("end_mode", 32'(mode_o), 32'(sel_i));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
